// File: rtl/trace_port_arbiter_if.sv
// rtl/trace_port_arbiter_if.sv - source and tracer-port handshake bundle for trace_port_arbiter
interface trace_port_arbiter_if #(
    parameter int NUM_SRC  = 3,
    parameter int REC_BITS = 600
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]          src_valid;
    logic [NUM_SRC-1:0]          src_ready;
    logic [NUM_SRC*REC_BITS-1:0] src_rec;
    logic                        out_valid;
    logic                        out_ready;
    logic [REC_BITS-1:0]         out_rec;
    logic [SRC_W-1:0]            out_src;

    modport master (
        output src_valid, src_rec, out_ready,
        input  src_ready, out_valid, out_rec, out_src
    );

    modport slave (
        input  src_valid, src_rec, out_ready,
        output src_ready, out_valid, out_rec, out_src
    );
endinterface

// File: rtl/trace_port_arbiter.sv
// rtl/trace_port_arbiter.sv - round-robin merge of writeback trace records into one tracer port
module trace_port_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int REC_BITS   = 600,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_BITS   = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    trace_port_arbiter_if.slave       tp,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic                      drain_req,
    input  logic                      start,
    output logic                      drain_done,
    output logic [CNT_BITS-1:0]       emit_count
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    rr_q, rr_d;
    logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [REC_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [REC_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [SRC_W-1:0]    tag_q [FIFO_DEPTH];
    logic [SRC_W-1:0]    tag_d [FIFO_DEPTH];

    logic [NUM_SRC-1:0]  eligible;
    logic                gnt_vld;
    logic [SRC_W-1:0]    gnt_idx;
    logic [REC_BITS-1:0] gnt_rec;
    logic                full, empty, accept_en, push, pop;
    int                  idx;

    assign empty = (wr_q == rd_q);
    assign full  = ((wr_q - rd_q) == PW'(FIFO_DEPTH));
    assign pop   = !empty && tp.out_ready;

    // Cyclic search starting at the round-robin pointer.
    always_comb begin
        eligible = tp.src_valid & src_en;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        idx      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!gnt_vld && eligible[SRC_W'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = SRC_W'(idx);
            end
        end
        gnt_rec = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (gnt_idx == SRC_W'(k)) gnt_rec = tp.src_rec[REC_BITS*k +: REC_BITS];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (empty)     state_d = ST_IDLE;
            ST_IDLE:  if (start)     state_d = ST_RUN;
            default:                 state_d = ST_RUN;
        endcase
    end

    // src_ready is forced low while reset is held, even though state already reads RUN.
    always_comb begin
        accept_en    = (state_q == ST_RUN) && !full && reset;
        push         = gnt_vld && accept_en;
        drain_done   = (state_q == ST_DRAIN) && empty;
        tp.src_ready = '0;
        if (push) tp.src_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        rr_d  = rr_q;
        mem_d = mem_q;
        tag_d = tag_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = gnt_rec;
            tag_d[wr_q[AW-1:0]] = gnt_idx;
            wr_d = wr_q + 1'b1;
            rr_d = (int'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
        end
        if (pop) begin
            rd_d  = rd_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            rr_q  <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
            mem_q <= mem_d;
            tag_q <= tag_d;
        end
    end

    assign tp.out_valid = !empty;
    assign tp.out_rec   = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign tp.out_src   = empty ? '0 : tag_q[rd_q[AW-1:0]];
    assign emit_count   = cnt_q;
endmodule

// File: tb/tb_trace_port_arbiter.sv
// tb/tb_trace_port_arbiter.sv - directed self-checking bench for trace_port_arbiter
module tb_trace_port_arbiter;
    logic clk;
    logic rst_n;

    trace_port_arbiter_if #(.NUM_SRC(3), .REC_BITS(600)) tp ();
    trace_port_arbiter_if #(.NUM_SRC(3), .REC_BITS(8))   tp2 ();

    logic [2:0]  src_en, src_en2;
    logic        drain_req, start, drain_done;
    logic        drain_req2, start2, drain_done2;
    logic [31:0] emit_count;
    logic [3:0]  emit_count2;

    trace_port_arbiter #(.NUM_SRC(3), .REC_BITS(600), .FIFO_DEPTH(4), .CNT_BITS(32)) dut (
        .clock(clk), .reset(rst_n), .tp(tp.slave), .src_en(src_en),
        .drain_req(drain_req), .start(start), .drain_done(drain_done), .emit_count(emit_count)
    );

    trace_port_arbiter #(.NUM_SRC(3), .REC_BITS(8), .FIFO_DEPTH(4), .CNT_BITS(4)) dut_wrap (
        .clock(clk), .reset(rst_n), .tp(tp2.slave), .src_en(src_en2),
        .drain_req(drain_req2), .start(start2), .drain_done(drain_done2), .emit_count(emit_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int src;
        int rec;
    } exp_t;

    exp_t sb[$];
    int   seq [3];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_recs();
        logic [31:0] s;
        for (int i = 0; i < 3; i++) begin
            s = seq[i];
            tp.src_rec[600*i +: 600] = {s, 536'b0, s};
        end
    endtask

    // One clock: check outputs at negedge, update the expected-record queue at posedge.
    task automatic cyc(input int exp_g, input bit exp_done);
        logic [2:0] er;
        exp_t       e;
        er = (exp_g < 0) ? 3'b000 : 3'(1 << exp_g);
        @(negedge clk);
        check("src_ready", 64'(tp.src_ready), 64'(er));
        check("drain_done", 64'(drain_done), 64'(exp_done));
        check("emit_count", 64'(emit_count), 64'(exp_cnt));
        if (sb.size() > 0) begin
            e = sb[0];
            check("out_valid", 64'(tp.out_valid), 64'd1);
            check("out_src", 64'(tp.out_src), 64'(e.src));
            check("out_rec_lo", 64'(tp.out_rec[31:0]), 64'(e.rec));
            check("out_rec_hi", 64'(tp.out_rec[599:568]), 64'(e.rec));
        end else begin
            check("out_valid", 64'(tp.out_valid), 64'd0);
        end
        @(posedge clk);
        if (tp.out_ready && sb.size() > 0) begin
            void'(sb.pop_front());
            exp_cnt++;
        end
        if (exp_g >= 0) begin
            e.src = exp_g;
            e.rec = seq[exp_g];
            sb.push_back(e);
            seq[exp_g]++;
        end
        #1;
        drive_recs();
    endtask

    initial begin
        rst_n = 1'b0;
        seq[0] = 'h10; seq[1] = 'hA5; seq[2] = 'h30;
        tp.src_valid = 3'b010;
        tp.out_ready = 1'b1;
        drive_recs();
        src_en = 3'b111;
        drain_req = 1'b0;
        start = 1'b0;
        tp2.src_valid = '0;
        tp2.src_rec = '0;
        tp2.out_ready = 1'b0;
        src_en2 = 3'b111;
        drain_req2 = 1'b0;
        start2 = 1'b0;

        // Reset values with a source already requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_src_ready", 64'(tp.src_ready), 64'd0);
        check("rst_out_valid", 64'(tp.out_valid), 64'd0);
        check("rst_out_rec", 64'(tp.out_rec[63:0]), 64'd0);
        check("rst_out_src", 64'(tp.out_src), 64'd0);
        check("rst_drain_done", 64'(drain_done), 64'd0);
        check("rst_emit_count", 64'(emit_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single source, record 0xA5.
        cyc(1, 0);
        tp.src_valid = 3'b000;
        cyc(-1, 0);
        cyc(-1, 0);

        // 2: all sources, continuous drain.
        tp.src_valid = 3'b111;
        cyc(2, 0); cyc(0, 0); cyc(1, 0); cyc(2, 0); cyc(0, 0); cyc(1, 0);
        tp.src_valid = 3'b000;
        cyc(-1, 0);

        // 3: fill to depth, then release the tracer.
        tp.out_ready = 1'b0;
        tp.src_valid = 3'b111;
        cyc(2, 0); cyc(0, 0); cyc(1, 0); cyc(2, 0); cyc(-1, 0); cyc(-1, 0);
        tp.out_ready = 1'b1;
        cyc(-1, 0); cyc(0, 0); cyc(1, 0); cyc(2, 0);
        tp.src_valid = 3'b000;
        cyc(-1, 0); cyc(-1, 0); cyc(-1, 0);

        // 4: source 1 masked.
        src_en = 3'b101;
        tp.src_valid = 3'b111;
        cyc(0, 0); cyc(2, 0); cyc(0, 0); cyc(2, 0);
        tp.src_valid = 3'b000;
        cyc(-1, 0);
        src_en = 3'b111;

        // 5: drain with three records buffered, then restart.
        tp.out_ready = 1'b0;
        tp.src_valid = 3'b111;
        cyc(0, 0); cyc(1, 0); cyc(2, 0);
        tp.src_valid = 3'b000;
        tp.out_ready = 1'b1;
        drain_req = 1'b1;
        cyc(-1, 0);
        drain_req = 1'b0;
        tp.src_valid = 3'b111;
        cyc(-1, 0); cyc(-1, 0); cyc(-1, 1); cyc(-1, 0);
        start = 1'b1;
        cyc(-1, 0);
        start = 1'b0;
        cyc(0, 0);

        // 6: asynchronous reset with two records buffered.
        tp.out_ready = 1'b0;
        cyc(1, 0);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(tp.out_valid), 64'd0);
        check("async_src_ready", 64'(tp.src_ready), 64'd0);
        check("async_emit_count", 64'(emit_count), 64'd0);
        sb.delete();
        exp_cnt = 0;
        tp.src_valid = 3'b000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(-1, 0);
        tp.out_ready = 1'b1;
        tp.src_valid = 3'b111;
        cyc(0, 0);
        tp.src_valid = 3'b000;
        cyc(-1, 0);
        cyc(-1, 0);

        // 4-bit counter build: 17 pops wrap to 1.
        tp2.out_ready = 1'b1;
        tp2.src_valid = 3'b001;
        for (int i = 0; i < 17; i++) begin
            tp2.src_rec[7:0] = 8'(i);
            @(posedge clk); #1;
        end
        tp2.src_valid = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wrap_emit_count", 64'(emit_count2), 64'd1);
        check("wrap_out_valid", 64'(tp2.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
